relay_framer: RTL

Parametrised relay framing controller for the hi-simulate relay path. It takes decoded nibbles from the demodulator and tracks frame start and end per relay role (fake reader / fake tag). It drives the front-end `mod_type` and re-serialises received nibbles onto `data_out` through a small FIFO, so back-to-back nibbles are never overwritten. It adds four things the single-shot relay logic lacked: idle timeout, frame length reporting, overflow flagging and byte-alignment checks.

---
 rtl/relay_framer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/relay_framer.sv
// rtl/relay_framer.sv - relay framing controller: start/end/timeout detection, mod_type drive, FIFO-backed nibble serializer
module relay_framer #(
    parameter int                   NIBBLE_W     = 4,
    parameter int                   FIFO_DEPTH   = 8,
    parameter int                   SHIFT_DIV    = 16,
    parameter int                   TIMEOUT      = 4096,
    parameter logic [NIBBLE_W-1:0]  READER_START = 4'hc,
    parameter logic [NIBBLE_W-1:0]  TAG_START    = 4'hf
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NIBBLE_W-1:0] data_in,
    input  logic                data_in_available,
    input  logic [2:0]          hi_simulate_mod_type,
    output logic [2:0]          mod_type,
    output logic                data_out,
    output logic [7:0]          frame_len,
    output logic                frame_done,
    output logic                frame_timeout,
    output logic                overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(SHIFT_DIV);
    localparam int BW = (NIBBLE_W > 1) ? $clog2(NIBBLE_W) : 1;
    localparam int IW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {ST_IDLE, ST_LISTEN, ST_MOD} state_t;
    typedef enum logic [1:0] {ROLE_NONE, ROLE_READER, ROLE_TAG} role_t;

    state_t state_q, state_d;
    role_t  role_q, role_now;

    // hist_q[0] is the most recent previously accepted nibble
    logic [3:0][NIBBLE_W-1:0] hist_q;
    logic [7:0]               cnt_q, cnt_inc;
    logic [IW-1:0]            idle_q;
    logic [NIBBLE_W-1:0]      fifo_mem [FIFO_DEPTH];
    logic [AW:0]              wr_ptr, rd_ptr;
    logic [NIBBLE_W-1:0]      sh_q;
    logic                     sh_busy;
    logic [DW-1:0]            div_q;
    logic [BW-1:0]            bit_q;

    logic                role_chg, strobe, start_hit, end_pat, end_hit, timeout_hit;
    logic                fifo_empty, fifo_full, sh_last, pop, push, drop;
    logic [NIBBLE_W-1:0] start_nib;

    always_comb begin
        role_now = ROLE_NONE;
        case (hi_simulate_mod_type)
            3'b101:  role_now = ROLE_READER;
            3'b110:  role_now = ROLE_TAG;
            default: role_now = ROLE_NONE;
        endcase
    end

    assign role_chg  = (role_now != role_q);
    assign strobe    = data_in_available && (role_q != ROLE_NONE) && !role_chg;
    assign cnt_inc   = (cnt_q == 8'hff) ? cnt_q : cnt_q + 8'd1;
    assign start_nib = (role_q == ROLE_READER) ? READER_START : TAG_START;
    assign start_hit = strobe && (state_q == ST_LISTEN) && (hist_q == '0) && (data_in == start_nib);

    // Window is oldest-first: hist_q[2], hist_q[1], hist_q[0], data_in
    assign end_pat = (role_q == ROLE_READER)
                   ? ((hist_q[1] == '0) && (hist_q[0] == '0) && (data_in == '0) &&
                      ((hist_q[2] == '0) || (hist_q[2] == READER_START)))
                   : ((hist_q[0] == '0) && (data_in == '0));
    assign end_hit     = strobe && (state_q == ST_MOD) && !cnt_inc[0] && end_pat;
    assign timeout_hit = !role_chg && !strobe && (state_q == ST_MOD) && (idle_q == IW'(TIMEOUT - 1));

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign sh_last    = sh_busy && (div_q == DW'(SHIFT_DIV - 1)) && (bit_q == BW'(NIBBLE_W - 1));
    // Reload on the last cycle of a nibble so back-to-back nibbles have no gap
    assign pop        = !role_chg && !fifo_empty && (!sh_busy || sh_last);
    assign push       = strobe && (!fifo_full || pop);
    assign drop       = strobe && fifo_full && !pop;
    assign data_out   = sh_busy && sh_q[NIBBLE_W-1];

    always_comb begin
        state_d  = state_q;
        mod_type = 3'b000;
        if (role_chg) begin
            if (role_now == ROLE_NONE) state_d = ST_IDLE;
            else                       state_d = ST_LISTEN;
        end else if (start_hit) begin
            state_d = ST_MOD;
        end else if (end_hit || timeout_hit) begin
            state_d = ST_LISTEN;
        end
        case (state_q)
            ST_LISTEN: mod_type = (role_q == ROLE_READER) ? 3'b011 : 3'b001;
            ST_MOD:    mod_type = (role_q == ROLE_READER) ? 3'b100 : 3'b010;
            default:   mod_type = 3'b000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            role_q  <= ROLE_NONE;
        end else begin
            state_q <= state_d;
            role_q  <= role_now;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= data_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q        <= '0;
            cnt_q         <= '0;
            idle_q        <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            sh_q          <= '0;
            sh_busy       <= 1'b0;
            div_q         <= '0;
            bit_q         <= '0;
            frame_len     <= '0;
            frame_done    <= 1'b0;
            frame_timeout <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            frame_done    <= 1'b0;
            frame_timeout <= 1'b0;
            if (role_chg) begin
                hist_q   <= '0;
                cnt_q    <= '0;
                idle_q   <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                sh_q     <= '0;
                sh_busy  <= 1'b0;
                div_q    <= '0;
                bit_q    <= '0;
                overflow <= 1'b0;
            end else begin
                if (strobe) hist_q <= {hist_q[2:0], data_in};

                if (start_hit) begin
                    cnt_q  <= 8'd1;
                    idle_q <= '0;
                end else if (state_q == ST_MOD) begin
                    if (strobe) begin
                        cnt_q  <= cnt_inc;
                        idle_q <= '0;
                        if (end_hit) begin
                            frame_len  <= cnt_inc;
                            frame_done <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        idle_q        <= '0;
                        frame_len     <= cnt_q;
                        frame_done    <= 1'b1;
                        frame_timeout <= 1'b1;
                    end else begin
                        idle_q <= idle_q + IW'(1);
                    end
                end

                if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
                if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
                if (drop) overflow <= 1'b1;

                if (pop) begin
                    sh_q    <= fifo_mem[rd_ptr[AW-1:0]];
                    sh_busy <= 1'b1;
                    div_q   <= '0;
                    bit_q   <= '0;
                end else if (sh_busy) begin
                    if (div_q == DW'(SHIFT_DIV - 1)) begin
                        div_q <= '0;
                        if (bit_q == BW'(NIBBLE_W - 1)) begin
                            sh_busy <= 1'b0;
                        end else begin
                            sh_q  <= sh_q << 1;
                            bit_q <= bit_q + BW'(1);
                        end
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
            end
        end
    end
endmodule
